// File: rtl/instr_encoder.sv
// Symbolic command -> RV32I word encoder feeding the instruction-memory write port.
// Optional XOR checksum of written words: define INSTR_ENCODER_CHECKSUM_EN.
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [31:0]       cmd_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              full,
  output logic [31:0]       checksum
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_J, F_U, F_H, F_BAD} fmt_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_word;
  logic            r_halt;
  logic [ADDR_W:0] r_count;
  logic            r_err;

  fmt_t        w_fmt;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [6:0]  w_opc;
  logic [31:0] w_word;
  logic        w_ok;
  logic        w_is_halt;
  logic        w_accept;
  logic        w_hs;
  logic        w_fit12, w_fit13, w_fit21;

  assign w_fit12 = (&cmd_imm[31:11]) | ~(|cmd_imm[31:11]);
  assign w_fit13 = (&cmd_imm[31:12]) | ~(|cmd_imm[31:12]);
  assign w_fit21 = (&cmd_imm[31:20]) | ~(|cmd_imm[31:20]);

  // Operation decode: format, funct fields and major opcode
  always_comb begin
    w_fmt = F_BAD;
    w_f3  = 3'd0;
    w_f7  = 7'd0;
    w_opc = 7'd0;
    case (cmd_op)
      5'd0:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd0; end
      5'd1:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd0; w_f7 = 7'b0100000; end
      5'd2:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd7; end
      5'd3:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd6; end
      5'd4:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd4; end
      5'd5:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd2; end
      5'd6:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd1; end
      5'd7:  begin w_fmt = F_R; w_opc = 7'b0110011; w_f3 = 3'd5; end
      5'd8:  begin w_fmt = F_I; w_opc = 7'b0010011; w_f3 = 3'd0; end
      5'd9:  begin w_fmt = F_I; w_opc = 7'b0010011; w_f3 = 3'd7; end
      5'd10: begin w_fmt = F_I; w_opc = 7'b0010011; w_f3 = 3'd6; end
      5'd11: begin w_fmt = F_I; w_opc = 7'b0000011; w_f3 = 3'd2; end
      5'd12: begin w_fmt = F_I; w_opc = 7'b0000011; w_f3 = 3'd1; end
      5'd13: begin w_fmt = F_S; w_opc = 7'b0100011; end
      5'd14: begin w_fmt = F_B; w_opc = 7'b1100011; end
      5'd15: begin w_fmt = F_J; w_opc = 7'b1101111; end
      5'd16: begin w_fmt = F_U; w_opc = 7'b0110111; end
      5'd17: begin w_fmt = F_I; w_opc = 7'b1100111; w_f3 = 3'd0; end
      5'd18: w_fmt = F_H;
      default: w_fmt = F_BAD;
    endcase
  end

  // Field assembly and immediate legality
  always_comb begin
    w_word    = 32'd0;
    w_ok      = 1'b1;
    w_is_halt = 1'b0;
    case (w_fmt)
      F_R: w_word = {w_f7, cmd_rs2, cmd_rs1, w_f3, cmd_rd, w_opc};
      F_I: begin
        w_word = {cmd_imm[11:0], cmd_rs1, w_f3, cmd_rd, w_opc};
        w_ok   = w_fit12;
      end
      F_S: begin
        w_word = {cmd_imm[11:5], cmd_rs2, cmd_rs1, w_f3, cmd_imm[4:0], w_opc};
        w_ok   = w_fit12;
      end
      F_B: begin
        w_word = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, w_f3,
                  cmd_imm[4:1], cmd_imm[11], w_opc};
        w_ok   = w_fit13 & ~cmd_imm[0];
      end
      F_J: begin
        w_word = {cmd_imm[20], cmd_imm[10:1], cmd_imm[11], cmd_imm[19:12], cmd_rd, w_opc};
        w_ok   = w_fit21 & ~cmd_imm[0];
      end
      F_U: begin
        w_word = {cmd_imm[31:12], cmd_rd, w_opc};
        w_ok   = (cmd_imm[11:0] == 12'd0);
      end
      F_H: begin
        w_word    = 32'hFFFF_FFFF;
        w_is_halt = 1'b1;
      end
      default: w_ok = 1'b0;
    endcase
  end

  // The last slot is reserved so HALT can always terminate the program
  assign w_accept = w_ok & (w_is_halt | ~full);
  assign w_hs     = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (start) begin
      w_state_next = S_ACCEPT;
    end else begin
      case (r_state)
        S_ACCEPT: if (w_hs && w_accept) w_state_next = S_WRITE;
        S_WRITE:  w_state_next = r_halt ? S_DONE : S_ACCEPT;
        default:  w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= 32'd0;
      r_halt  <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (start) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_ACCEPT && w_hs) begin
        if (w_accept) begin
          r_word <= w_word;
          r_halt <= w_is_halt;
        end else begin
          r_err <= 1'b1;
        end
      end
      if (r_state == S_WRITE) r_count <= r_count + ONE;
    end
  end

`ifdef INSTR_ENCODER_CHECKSUM_EN
  logic [31:0] r_checksum;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_checksum <= 32'd0;
    else if (start)              r_checksum <= 32'd0;
    else if (r_state == S_WRITE) r_checksum <= r_checksum ^ r_word;
  end
  assign checksum = r_checksum;
`else
  assign checksum = 32'd0;
`endif

  assign cmd_ready = (r_state == S_ACCEPT);
  assign mem_we    = (r_state == S_WRITE);
  assign mem_addr  = r_count[ADDR_W-1:0];
  assign mem_wdata = r_word;
  assign count     = r_count;
  assign busy      = (r_state == S_ACCEPT) || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign full      = (r_count == LAST_SLOT);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-size instance plus an ADDR_W=2 instance
// for the full/halt-slot boundary; both share the command bus, each has its own start.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_s = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [4:0]  cmd_op = '0, cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [31:0] cmd_imm = '0;

  logic        cmd_ready, mem_we, busy, done, err, full;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, checksum;
  logic [6:0]  count;

  logic        s_cmd_ready, s_mem_we, s_busy, s_done, s_err, s_full;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata, s_checksum;
  logic [2:0]  s_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(6)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .count(count),
    .busy(busy), .done(done), .err(err), .full(full), .checksum(checksum)
  );

  instr_encoder #(.ADDR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .count(s_count),
    .busy(s_busy), .done(s_done), .err(s_err), .full(s_full), .checksum(s_checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_s = 1'b1; else start = 1'b1;
    step();
    start_s = 1'b0;
    start   = 1'b0;
  endtask

  // Present one command and hold it until it is taken (bounded wait)
  task automatic send(input bit sel, input logic [4:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    bit hs;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 20 && !hs; i++) begin
      hs = sel ? s_cmd_ready : cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!hs) check("handshake_timeout", 32'(hs), 32'd1);
  endtask

  task automatic wr(input string tag, input bit sel, input logic [4:0] op, input logic [4:0] rd,
                    input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                    input int exp_addr, input logic [31:0] exp_word);
    send(sel, op, rd, rs1, rs2, imm);
    check({tag, "_we"},   32'(sel ? s_mem_we : mem_we), 32'd1);
    check({tag, "_addr"}, sel ? 32'(s_mem_addr) : 32'(mem_addr), 32'(exp_addr));
    check({tag, "_data"}, sel ? s_mem_wdata : mem_wdata, exp_word);
    step();
    check({tag, "_we_off"}, 32'(sel ? s_mem_we : mem_we), 32'd0);
    check({tag, "_count"}, sel ? 32'(s_count) : 32'(count), 32'(exp_addr + 1));
    $display("write %s: addr %0d data %h", tag, exp_addr, exp_word);
  endtask

  task automatic rej(input string tag, input bit sel, input logic [4:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                     input int exp_count);
    send(sel, op, rd, rs1, rs2, imm);
    check({tag, "_we"},    32'(sel ? s_mem_we : mem_we), 32'd0);
    check({tag, "_err"},   32'(sel ? s_err : err), 32'd1);
    check({tag, "_ready"}, 32'(sel ? s_cmd_ready : cmd_ready), 32'd1);
    check({tag, "_count"}, sel ? 32'(s_count) : 32'(count), 32'(exp_count));
    $display("reject %s: err %0d count %0d", tag, sel ? s_err : err, sel ? s_count : count);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_flags", {28'd0, busy, done, err, full}, 32'd0);
    check("rst_csum",  checksum, 32'd0);
    check("rst_small", {27'd0, s_cmd_ready, s_busy, s_done, s_err, s_full}, 32'd0);
    $display("reset: state checked");
    rst_n = 1'b1;
    step();

    pulse_start(1'b0);
    check("start_ready", 32'(cmd_ready), 32'd1);
    check("start_busy",  32'(busy), 32'd1);
    wr("add", 1'b0, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3);

    pulse_start(1'b0);
    check("restart_count", 32'(count), 32'd0);
    wr("sub",  1'b0, 5'd1,  5'd1, 5'd2, 5'd3, 32'd0, 0, 32'h403100B3);
    wr("addi", 1'b0, 5'd8,  5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 32'hFFF00293);
    wr("beq",  1'b0, 5'd14, 5'd0, 5'd1, 5'd2, 32'd8, 2, 32'h00208463);
    rej("beq_odd", 1'b0, 5'd14, 5'd0, 5'd1, 5'd2, 32'd7, 3);
    wr("lw",   1'b0, 5'd11, 5'd4, 5'd2, 5'd0, 32'd16, 3, 32'h01012203);
    wr("sb",   1'b0, 5'd13, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC, 4, 32'hFE310E23);
    wr("lui",  1'b0, 5'd16, 5'd7, 5'd0, 5'd0, 32'h12345000, 5, 32'h123453B7);
    wr("jal",  1'b0, 5'd15, 5'd1, 5'd0, 5'd0, 32'd2048, 6, 32'h001000EF);
    rej("bad_op",  1'b0, 5'd19, 5'd1, 5'd1, 5'd1, 32'd0, 7);
    rej("lui_low", 1'b0, 5'd16, 5'd1, 5'd0, 5'd0, 32'h12345001, 7);

    // start beats a concurrent handshake
    cmd_op = 5'd0; cmd_rd = 5'd3; cmd_rs1 = 5'd1; cmd_rs2 = 5'd2; cmd_imm = 32'd0;
    cmd_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    cmd_valid = 1'b0;
    check("prio_we",    32'(mem_we), 32'd0);
    check("prio_count", 32'(count), 32'd0);
    check("prio_err",   32'(err), 32'd0);
    check("prio_ready", 32'(cmd_ready), 32'd1);
    $display("start-vs-handshake: count %0d err %0d", count, err);

    rej("addi_2048", 1'b0, 5'd8, 5'd5, 5'd0, 5'd0, 32'd2048, 0);
    pulse_start(1'b0);
    check("err_cleared", 32'(err), 32'd0);

    wr("add2", 1'b0, 5'd0,  5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3);
    wr("halt", 1'b0, 5'd18, 5'd0, 5'd0, 5'd0, 32'd0, 1, 32'hFFFFFFFF);
    check("halt_done",  32'(done), 32'd1);
    check("halt_ready", 32'(cmd_ready), 32'd0);
    check("halt_busy",  32'(busy), 32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
    check("checksum", checksum, 32'hFFDF7E4C);
`else
    check("checksum", checksum, 32'd0);
`endif
    pulse_start(1'b0);
    check("redo_ready", 32'(cmd_ready), 32'd1);
    check("redo_count", 32'(count), 32'd0);
    check("redo_csum",  checksum, 32'd0);

    // asynchronous reset in the middle of a write
    send(1'b0, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    check("mid_we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we_after", 32'(mem_we), 32'd0);
    check("mid_idle", {29'd0, cmd_ready, busy, done}, 32'd0);
    check("mid_count", 32'(count), 32'd0);
    $display("reset mid-write: mem_we %0d busy %0d", mem_we, busy);
    step();
    rst_n = 1'b1;
    step();

    // small instance: fill to the halt slot
    pulse_start(1'b1);
    wr("s_add0", 1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3);
    wr("s_add1", 1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3);
    check("s_notfull", 32'(s_full), 32'd0);
    wr("s_add2", 1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 2, 32'h002081B3);
    check("s_full", 32'(s_full), 32'd1);
    rej("s_add_full", 1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 3);
    wr("s_halt", 1'b1, 5'd18, 5'd0, 5'd0, 5'd0, 32'd0, 3, 32'hFFFFFFFF);
    check("s_done",  32'(s_done), 32'd1);
    check("s_ready", 32'(s_cmd_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
